// File: rtl/quad_decoder_counter_if.sv
`default_nettype none
// ============================================================================
// Module      : quad_decoder_counter_if
// Description : Signal bundle between the encoder pins / control logic and
//               the quadrature decoder.
//               master : drives A, B, mode, clr, err_clr; observes results
//               slave  : the decoder itself
//               Signals: A, B (encoder channels), mode[1:0], clr, err_clr,
//                        count[CNT_W-1:0], dir[1:0], step, wrap, err
// Revision    : 1.0 - initial release
// ============================================================================
interface quad_decoder_counter_if #(
    parameter int CNT_W = 16
);
    logic                    A;
    logic                    B;
    logic [1:0]              mode;
    logic                    clr;
    logic                    err_clr;
    logic signed [CNT_W-1:0] count;
    logic [1:0]              dir;
    logic                    step;
    logic                    wrap;
    logic                    err;

    modport master (
        output A, B, mode, clr, err_clr,
        input  count, dir, step, wrap, err
    );

    modport slave (
        input  A, B, mode, clr, err_clr,
        output count, dir, step, wrap, err
    );
endinterface
`default_nettype wire

// File: rtl/quad_decoder_counter.sv
`default_nettype none
// ============================================================================
// Module      : quad_decoder_counter
// Description : Quadrature decoder with input synchroniser, run-length glitch
//               filter, X4/X2/X1 decoding, wrapping signed position counter,
//               held direction with idle timeout and sticky illegal flag.
//               clk   : system clock, rising edge
//               rst_n : asynchronous reset, active-high (name kept for
//                       compatibility with the existing codebase)
//               bus   : slave side of quad_decoder_counter_if
// Revision    : 1.0 - initial release
// ============================================================================
module quad_decoder_counter #(
    parameter int CNT_W    = 16,
    parameter int FILT_LEN = 3,
    parameter int IDLE_CYC = 1024
) (
    input  logic                    clk,
    input  logic                    rst_n,
    quad_decoder_counter_if.slave   bus
);
    localparam int c_run_w  = $clog2(FILT_LEN + 1);
    localparam int c_idle_w = $clog2(IDLE_CYC + 1);

    localparam logic [c_run_w-1:0]  c_filt_len = c_run_w'(FILT_LEN);
    localparam logic [c_idle_w-1:0] c_idle_max = c_idle_w'(IDLE_CYC);

    localparam logic [1:0] c_mode_x2  = 2'b01;
    localparam logic [1:0] c_mode_x1  = 2'b10;
    localparam logic [1:0] c_dir_idle = 2'b00;
    localparam logic [1:0] c_dir_cw   = 2'b01;
    localparam logic [1:0] c_dir_ccw  = 2'b10;

    localparam logic signed [CNT_W-1:0] c_cnt_max = {1'b0, {(CNT_W-1){1'b1}}};
    localparam logic signed [CNT_W-1:0] c_cnt_min = {1'b1, {(CNT_W-1){1'b0}}};
    localparam logic signed [CNT_W-1:0] c_cnt_one = CNT_W'(1);

    logic [1:0]              r_sync1;
    logic [1:0]              r_sync2;
    logic [1:0]              r_cand;
    logic [c_run_w-1:0]      r_run;
    logic [1:0]              r_acc;
    logic                    r_primed;
    logic [c_idle_w-1:0]     r_idle;
    logic signed [CNT_W-1:0] r_count;
    logic [1:0]              r_dir;
    logic                    r_step;
    logic                    r_wrap;
    logic                    r_err;

    logic                    w_event;
    logic                    w_decode;
    logic [1:0]              w_delta;
    logic                    w_qual;
    logic                    w_up;
    logic                    w_dn;
    logic                    w_illegal;
    logic [c_idle_w-1:0]     w_idle_next;

    // Position of an A/B state along the CW sequence 00->10->11->01.
    function automatic logic [1:0] f_pos(input logic [1:0] ab);
        case (ab)
            2'b00:   f_pos = 2'd0;
            2'b10:   f_pos = 2'd1;
            2'b11:   f_pos = 2'd2;
            default: f_pos = 2'd3;
        endcase
    endfunction

    // The first accepted state after reset is taken even when it equals the
    // reset value of acc, so a stationary encoder still primes the decoder.
    assign w_event  = (r_run == c_filt_len) && (!r_primed || (r_cand != r_acc));
    assign w_decode = w_event && r_primed;

    // Distance around the cycle: 1 = CW, 3 = CCW, 2 = both bits changed.
    assign w_delta   = f_pos(r_cand) - f_pos(r_acc);
    assign w_illegal = w_decode && (w_delta == 2'd2);

    always_comb begin
        w_qual = 1'b1;
        case (bus.mode)
            c_mode_x2: w_qual = r_cand[1] ^ r_acc[1];
            c_mode_x1: w_qual = ((r_acc == 2'b00) && (r_cand == 2'b10)) ||
                                ((r_acc == 2'b10) && (r_cand == 2'b00));
            default:   w_qual = 1'b1;
        endcase
    end

    assign w_up = w_decode && w_qual && (w_delta == 2'd1);
    assign w_dn = w_decode && w_qual && (w_delta == 2'd3);

    assign w_idle_next = (w_up || w_dn)         ? '0 :
                         (r_idle == c_idle_max) ? r_idle :
                                                  r_idle + 1'b1;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_sync1  <= 2'b00;
            r_sync2  <= 2'b00;
            r_cand   <= 2'b00;
            r_run    <= '0;
            r_acc    <= 2'b00;
            r_primed <= 1'b0;
            r_idle   <= '0;
            r_count  <= '0;
            r_dir    <= c_dir_idle;
            r_step   <= 1'b0;
            r_wrap   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_sync1 <= {bus.A, bus.B};
            r_sync2 <= r_sync1;

            // Run-length filter: run saturates at FILT_LEN while stable.
            if (r_sync2 != r_cand) begin
                r_cand <= r_sync2;
                r_run  <= c_run_w'(1);
            end else if (r_run != c_filt_len) begin
                r_run  <= r_run + 1'b1;
            end

            if (w_event) begin
                r_acc    <= r_cand;
                r_primed <= 1'b1;
            end

            r_step <= w_up || w_dn;
            r_idle <= w_idle_next;

            if (w_up) begin
                r_dir <= c_dir_cw;
            end else if (w_dn) begin
                r_dir <= c_dir_ccw;
            end else if (w_idle_next == c_idle_max) begin
                r_dir <= c_dir_idle;
            end

            // clr discards a coincident step from count (and its wrap).
            if (bus.clr) begin
                r_count <= '0;
                r_wrap  <= 1'b0;
            end else if (w_up) begin
                r_count <= r_count + c_cnt_one;
                r_wrap  <= (r_count == c_cnt_max);
            end else if (w_dn) begin
                r_count <= r_count - c_cnt_one;
                r_wrap  <= (r_count == c_cnt_min);
            end else begin
                r_wrap  <= 1'b0;
            end

            if (w_illegal) begin
                r_err <= 1'b1;
            end else if (bus.err_clr) begin
                r_err <= 1'b0;
            end
        end
    end

    assign bus.count = r_count;
    assign bus.dir   = r_dir;
    assign bus.step  = r_step;
    assign bus.wrap  = r_wrap;
    assign bus.err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_quad_decoder_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_quad_decoder_counter
// Description : Self-checking bench for quad_decoder_counter (CNT_W=4,
//               FILT_LEN=3, IDLE_CYC=1024). Stimulus pushes the expected
//               {count, dir, wrap} of every counted step into a queue; a
//               monitor pops and compares whenever step pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_quad_decoder_counter;
    localparam int CNT_W = 4;

    typedef struct packed {
        logic signed [CNT_W-1:0] count;
        logic [1:0]              dir;
        logic                    wrap;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;

    quad_decoder_counter_if #(.CNT_W(CNT_W)) bus ();

    quad_decoder_counter #(
        .CNT_W    (CNT_W),
        .FILT_LEN (3),
        .IDLE_CYC (1024)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp   = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int n_stray = 0;
    int n_wraps = 0;
    exp_t exp_q[$];
    logic signed [CNT_W-1:0] exp_cnt = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp_v);
        n_cmp++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d (t=%0t)", nm, act, exp_v, $time);
        end
    endtask

    // Monitor: every step pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst_n) begin
            if (bus.wrap) n_wraps++;
            if (bus.step) begin
                if (exp_q.size() == 0) begin
                    n_stray++;
                    $display("FAIL stray_step: actual step=1 required no step (t=%0t)", $time);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("step_count", int'(bus.count), int'(e.count));
                    chk("step_dir",   int'(bus.dir),   int'(e.dir));
                    chk("step_wrap",  int'(bus.wrap),  int'(e.wrap));
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_step(input int delta);
        exp_t e;
        e.wrap  = ((delta > 0) && (exp_cnt == 4'sd7)) || ((delta < 0) && (exp_cnt == -4'sd8));
        exp_cnt = exp_cnt + CNT_W'(delta);
        e.count = exp_cnt;
        e.dir   = (delta > 0) ? 2'b01 : 2'b10;
        exp_q.push_back(e);
    endtask

    task automatic drive_ab(input logic [1:0] ab);
        bus.A = ab[1];
        bus.B = ab[0];
    endtask

    // delta is the hand-computed count change for this transition in the
    // current mode (0 = not counted).
    task automatic move(input logic [1:0] ab, input int delta, input int hold);
        if (delta != 0) push_step(delta);
        drive_ab(ab);
        tick(hold);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int   cyc0;
        bit   seen;
        exp_t e;

        rst_n       = 1'b1;
        bus.A       = 1'b0;
        bus.B       = 1'b0;
        bus.mode    = 2'b00;
        bus.clr     = 1'b0;
        bus.err_clr = 1'b0;
        tick(3);
        chk("rst_count", int'(bus.count), 0);
        chk("rst_dir",   int'(bus.dir),   0);
        chk("rst_step",  int'(bus.step),  0);
        chk("rst_wrap",  int'(bus.wrap),  0);
        chk("rst_err",   int'(bus.err),   0);

        // Priming on 11: no step, no error, count untouched.
        rst_n = 1'b0;
        move(2'b11, 0, 10);
        chk("prime_count", int'(bus.count), 0);
        chk("prime_err",   int'(bus.err),   0);

        // Reset again and prime on 00.
        rst_n = 1'b1;
        move(2'b00, 0, 2);
        rst_n = 1'b0;
        tick(10);

        // X4 full CW cycle, then reverse.
        move(2'b10, +1, 8);
        move(2'b11, +1, 8);
        move(2'b01, +1, 8);
        move(2'b00, +1, 8);
        chk("x4_cw_count", int'(bus.count), 4);
        chk("x4_cw_dir",   int'(bus.dir),   1);
        move(2'b01, -1, 8);
        move(2'b11, -1, 8);
        move(2'b10, -1, 8);
        move(2'b00, -1, 8);
        chk("x4_ccw_count", int'(bus.count), 0);
        chk("x4_ccw_dir",   int'(bus.dir),   2);

        // 2-cycle glitch on A is rejected.
        move(2'b10, 0, 2);
        move(2'b00, 0, 10);
        chk("glitch_count", int'(bus.count), 0);

        // 3-cycle pulse is accepted (+1) and its release is a CCW step.
        move(2'b10, +1, 3);
        move(2'b00, -1, 10);

        // Latency: a held change appears on the 6th edge.
        push_step(+1);
        drive_ab(2'b10);
        cyc0 = cyc;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (bus.step) seen = 1'b1;
        end
        chk("latency_seen",  int'(seen), 1);
        chk("latency_edges", cyc - cyc0, 6);
        tick(4);
        chk("pulse_count", int'(bus.count), 1);
        move(2'b00, -1, 8);

        // X2: 3 CW cycles, only A edges count.
        bus.mode = 2'b01;
        for (int c = 0; c < 3; c++) begin
            move(2'b10, +1, 8);
            move(2'b11,  0, 8);
            move(2'b01, +1, 8);
            move(2'b00,  0, 8);
        end
        chk("x2_count", int'(bus.count), 6);

        bus.clr = 1'b1;
        tick(1);
        bus.clr = 1'b0;
        exp_cnt = '0;
        chk("clr_count", int'(bus.count), 0);

        // X1: only 00->10 counts.
        bus.mode = 2'b10;
        for (int c = 0; c < 3; c++) begin
            move(2'b10, +1, 8);
            move(2'b11,  0, 8);
            move(2'b01,  0, 8);
            move(2'b00,  0, 8);
        end
        chk("x1_count", int'(bus.count), 3);

        // Wrap: 3 -> 7, then +1 -> -8 (wrap), then -1 -> 7 (wrap).
        bus.mode = 2'b00;
        move(2'b10, +1, 8);
        move(2'b11, +1, 8);
        move(2'b01, +1, 8);
        move(2'b00, +1, 8);
        chk("pre_wrap_count", int'(bus.count), 7);
        move(2'b10, +1, 8);
        chk("wrap_up_count", int'(bus.count), -8);
        move(2'b00, -1, 8);
        chk("wrap_dn_count", int'(bus.count), 7);

        // Illegal 00 -> 11.
        move(2'b11, 0, 8);
        chk("illegal_err",   int'(bus.err),   1);
        chk("illegal_count", int'(bus.count), 7);
        bus.err_clr = 1'b1;
        tick(1);
        bus.err_clr = 1'b0;
        chk("err_clr", int'(bus.err), 0);

        // clr coincident with a CW step (which would otherwise wrap 7 -> -8).
        e.count = '0;
        e.dir   = 2'b01;
        e.wrap  = 1'b0;
        exp_q.push_back(e);
        exp_cnt = '0;
        drive_ab(2'b01);
        tick(5);
        bus.clr = 1'b1;
        tick(1);
        bus.clr = 1'b0;
        tick(4);
        chk("clr_step_count", int'(bus.count), 0);

        // Idle timeout.
        tick(1000);
        chk("dir_before_idle", int'(bus.dir), 1);
        tick(30);
        chk("dir_after_idle", int'(bus.dir), 0);

        // Reset mid-operation takes effect without a clock edge.
        move(2'b00, +1, 8);
        chk("pre_reset_count", int'(bus.count), 1);
        #3;
        rst_n = 1'b1;
        #1;
        chk("async_rst_count", int'(bus.count), 0);
        chk("async_rst_dir",   int'(bus.dir),   0);
        tick(2);
        rst_n = 1'b0;
        tick(10);

        chk("queue_drained", exp_q.size(), 0);
        chk("stray_steps",   n_stray,      0);
        chk("wrap_pulses",   n_wraps,      2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/quad_decoder_counter.md
Name: quad_decoder_counter

Overview:
- Parametrised quadrature decoder. Successor to the team's 2-bit direction-only encoder reader.
- Synchronises and glitch-filters the A/B encoder inputs, then decodes in X4, X2 or X1 resolution.
- Maintains a signed, wrapping position counter, a held direction, and flags for illegal transitions.
- Sits between the encoder input pins and the motor/position control logic; single clock domain.

Parameters:
- CNT_W, 16, width of the signed position counter (2..32).
- FILT_LEN, 3, consecutive identical synchronised samples required before an A/B state is accepted (1..15).
- IDLE_CYC, 1024, cycles without a counted step before dir returns to 00 (≥2).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-high (rst_n=1 resets the block).
- A  in  1  encoder channel A; asynchronous to clk.
- B  in  1  encoder channel B; asynchronous to clk.
- mode  in  2  resolution: 00 = X4, 01 = X2, 10 = X1, 11 = X4.
- clr  in  1  synchronous clear of count.
- err_clr  in  1  synchronous clear of err.
- count  out  CNT_W  signed position, two's complement.
- dir  out  2  01 = CW, 10 = CCW, 00 = idle.
- step  out  1  one-cycle pulse on each counted step.
- wrap  out  1  one-cycle pulse when count wraps.
- err  out  1  sticky illegal-transition flag.

Behaviour:
- Reset (rst_n=1, asynchronous):
  - count=0, dir=00, step=0, wrap=0, err=0.
  - Synchronisers, filter counter, accepted state and idle timer cleared.
  - primed=0.
- Sync: 2-flop synchroniser per input, producing s={A_s,B_s}.
- Filter:
  - cand holds the last s value; run counts consecutive edges where s==cand.
  - When run reaches FILT_LEN and cand != acc: acc_next=cand and a decode event fires. acc is the accepted state.
  - When s changes: cand=s, run=1.
  - Pulses shorter than FILT_LEN cycles are never accepted.
- Priming: the first accepted value after reset loads acc only.
  - No count, no step, no err; primed is set to 1.
- Decode on event (prev=acc, new=cand):
  - CW transitions: 00→10, 10→11, 11→01, 01→00. CCW transitions: 00→01, 01→11, 11→10, 10→00.
  - Illegal (both bits change): err=1, no count, dir unchanged.
  - X4: every legal transition counts (+1 CW, −1 CCW).
  - X2: only transitions in which A changes count.
  - X1: only 00→10 (+1) and 10→00 (−1) count.
  - Legal non-counted transitions update acc only.
- Latency:
  - An input change held stable is reflected in count/step/dir on the (2+FILT_LEN+1)th rising edge after the change is first sampled.
  - With FILT_LEN=3 this is the 6th edge.
- Counted step:
  - step=1 for one cycle; dir=01 (CW) or 10 (CCW); idle timer reset to 0.
- Idle timer:
  - Increments each cycle without a counted step, saturating at IDLE_CYC.
  - On reaching IDLE_CYC, dir=00.
- Arithmetic: count wraps modulo 2^CNT_W.
  - +1 from 2^(CNT_W-1)−1 gives −2^(CNT_W-1), wrap=1.
  - −1 from −2^(CNT_W-1) gives max positive, wrap=1.
- clr:
  - count=0 next cycle. Wins over a simultaneous step; that step is discarded from count, but step and dir still update. wrap=0.
  - acc, filter and primed are unaffected.
- err_clr:
  - err=0. A simultaneous illegal event wins (err stays 1).
- mode change: takes effect on the next decode event; count is not altered.
- Reset mid-operation: all state returns to reset values immediately; priming repeats after release.

Test Plan:
- Reset, then A/B=11 held 10 cycles -> primed, count=0, err=0, step never pulses.
- X4, one full CW cycle 00→10→11→01→00, each state held 8 cycles -> count=4, 4 step pulses, dir=01. Reverse the sequence -> count=0, dir=10.
- Glitch on A of 2 cycles with FILT_LEN=3 -> no step, count unchanged. Same pulse held 3 cycles -> accepted, count=1. Latency from A change to count change = 6 edges.
- mode=01 then mode=10, 3 CW cycles each from count=0 -> X2 gives count=6; X1 gives count=3.
- CNT_W=4, count=7, one CW step -> count=−8 (4'b1000), wrap pulse. Then a CCW step -> count=7, wrap pulse.
- Illegal 00→11 -> err=1, count unchanged. err_clr -> err=0. clr coincident with step -> count=0, step=1. 1024 idle cycles -> dir=00.
